// File: rtl/rs232_pkg.sv
// rtl/rs232_pkg.sv - shared constants and encodings for the rs232 rx/tx pair
package rs232_pkg;

    // Frame geometry: 8N1 plus start and stop bits
    localparam int DATA_WIDTH        = 8;
    localparam int FRAME_BITS        = DATA_WIDTH + 2;

    // Shared default baud divisor so both ends of the link agree (50 MHz / 115200)
    localparam int DEFAULT_BAUD_DIV  = 434;
    localparam int DEFAULT_CNT_WIDTH = 16;

    // Transmitter FSM encoding
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_e;

    // Opcode driven by the FSM into the baud/bit counter
    typedef enum logic [1:0] {
        CNT_CLEAR = 2'b00,
        CNT_HOLD  = 2'b01,
        CNT_INC   = 2'b10
    } cnt_op_e;

    // Bit counter needs one extra bit so it can sit at DataWidth after the last data bit
    function automatic int bit_cnt_width(input int data_width);
        return $clog2(data_width) + 1;
    endfunction

endpackage

// File: rtl/counter_tx.sv
// rtl/counter_tx.sv - baud and bit counters for the rs232 transmitter
module counter_tx
    import rs232_pkg::*;
#(
    parameter int BaudDiv  = DEFAULT_BAUD_DIV,
    parameter int CntWidth = DEFAULT_CNT_WIDTH,
    parameter int BitWidth = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  cnt_op_e             op_i,
    input  logic                bit_en_i,
    output logic [CntWidth-1:0] baud_cnt_o,
    output logic [BitWidth-1:0] bit_cnt_o,
    output logic                wrap_o
);

    localparam logic [CntWidth-1:0] BaudLast = CntWidth'(BaudDiv - 1);

    // Wrap marks the last clock of the current serial bit
    assign wrap_o = (baud_cnt_o == BaudLast);

    // Baud counter runs 0..BaudDiv-1; the bit counter advances on each wrap when enabled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            baud_cnt_o <= '0;
            bit_cnt_o  <= '0;
        end else begin
            case (op_i)
                CNT_CLEAR: begin
                    baud_cnt_o <= '0;
                    bit_cnt_o  <= '0;
                end
                CNT_INC: begin
                    if (wrap_o) begin
                        baud_cnt_o <= '0;
                        if (bit_en_i) begin
                            bit_cnt_o <= bit_cnt_o + 1'b1;
                        end
                    end else begin
                        baud_cnt_o <= baud_cnt_o + 1'b1;
                    end
                end
                default: begin
                    baud_cnt_o <= baud_cnt_o;
                    bit_cnt_o  <= bit_cnt_o;
                end
            endcase
        end
    end

endmodule

// File: rtl/rs232_tx.sv
// rtl/rs232_tx.sv - 8N1 UART transmitter with registered outputs
module rs232_tx
    import rs232_pkg::*;
#(
    parameter int DataWidth = DATA_WIDTH,
    parameter int BaudDiv   = DEFAULT_BAUD_DIV,
    parameter int CntWidth  = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 ready_o,
    output logic                 done_o,
    output logic                 tx_o
);

    localparam int                  BitWidth   = bit_cnt_width(DataWidth);
    localparam logic [CntWidth-1:0] BaudPenult = CntWidth'(BaudDiv - 2);
    localparam logic [BitWidth-1:0] BitLast    = BitWidth'(DataWidth - 1);

    state_e                 state_q, state_d;
    logic [DataWidth-1:0]   shift_q, shift_d;
    logic [DataWidth-1:0]   shifted;
    logic                   tx_d, ready_d, done_d;
    cnt_op_e                cnt_op;
    logic [CntWidth-1:0]    baud_cnt;
    logic [BitWidth-1:0]    bit_cnt;
    logic                   baud_wrap;
    logic                   accept;

    counter_tx #(
        .BaudDiv  (BaudDiv),
        .CntWidth (CntWidth),
        .BitWidth (BitWidth)
    ) u_counter (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .op_i       (cnt_op),
        .bit_en_i   (state_q == DATA),
        .baud_cnt_o (baud_cnt),
        .bit_cnt_o  (bit_cnt),
        .wrap_o     (baud_wrap)
    );

    assign shifted = shift_q >> 1;
    assign accept  = ready_o && start_i;

    // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
    // ready_o/done_o rise in the final stop-bit cycle so a new start can be accepted on the
    // edge that ends the stop bit, giving gap-free back-to-back frames.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        tx_d    = tx_o;
        ready_d = ready_o;
        done_d  = 1'b0;
        cnt_op  = CNT_INC;

        case (state_q)
            IDLE: begin
                cnt_op  = CNT_CLEAR;
                tx_d    = 1'b1;
                ready_d = 1'b1;
            end
            START: begin
                if (baud_wrap) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    shift_d = shifted;
                    if (bit_cnt == BitLast) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d    = shifted[0];
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_cnt == BaudPenult) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end
                if (baud_wrap) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Acceptance overrides everything: capture the byte and begin the start bit
        if (accept) begin
            state_d = START;
            shift_d = data_i;
            tx_d    = 1'b0;
            ready_d = 1'b0;
            done_d  = 1'b0;
            cnt_op  = CNT_CLEAR;
        end
    end

    // State, shift register and line flops; reset forces the line to mark immediately
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            shift_q <= '0;
            tx_o    <= 1'b1;
            ready_o <= 1'b1;
            done_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            tx_o    <= tx_d;
            ready_o <= ready_d;
            done_o  <= done_d;
        end
    end

endmodule

// File: tb/tb_rs232_tx.sv
// tb/tb_rs232_tx.sv - self-checking bench for rs232_tx
module tb_rs232_tx;
    import rs232_pkg::*;

    localparam int BAUD  = 4;
    localparam int FRAME = FRAME_BITS * BAUD;

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // expected tx level per bit slot, slot 0 = start bit
        logic       chain;  // keep start_i high into the next frame
        logic       poke;   // pulse start_i mid-frame (must be ignored)
    } vec_t;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       start_i;
    logic [7:0] data_i;
    logic       ready_o;
    logic       done_o;
    logic       tx_o;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    vec_t       vecs[5];

    rs232_tx #(
        .DataWidth (8),
        .BaudDiv   (BAUD),
        .CntWidth  (16)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .done_o  (done_o),
        .tx_o    (tx_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk_i);
        while (!ready_o && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        check("ready_wait", {31'd0, ready_o}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input bit chained_in, input logic [7:0] next_data);
        if (!chained_in) begin
            wait_ready();
            start_i = 1'b1;
            data_i  = v.data;
        end
        exp_q.push_back(v.data);
        @(posedge clk_i);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk_i);
            if (i == 0) begin
                if (v.chain) data_i = next_data;
                else         start_i = 1'b0;
            end
            if (v.poke && i == 10) begin
                start_i = 1'b1;
                data_i  = 8'hFF;
            end
            if (v.poke && i == 11) start_i = 1'b0;
            check($sformatf("tx_%02h_c%0d", v.data, i), {31'd0, tx_o}, {31'd0, v.line[i / BAUD]});
            check($sformatf("done_%02h_c%0d", v.data, i), {31'd0, done_o}, (i == FRAME - 1) ? 32'd1 : 32'd0);
            check($sformatf("ready_%02h_c%0d", v.data, i), {31'd0, ready_o}, (i == FRAME - 1) ? 32'd1 : 32'd0);
        end
    endtask

    // Receiver model: decodes tx_o mid-bit and checks each byte against the scoreboard
    initial begin
        int         t;
        logic [7:0] sh;
        logic [7:0] exp_byte;
        bit         busy;
        busy = 1'b0;
        t    = 0;
        sh   = '0;
        forever begin
            @(negedge clk_i);
            if (rst_ni !== 1'b1) begin
                busy = 1'b0;
            end else if (!busy) begin
                if (tx_o == 1'b0) begin
                    busy = 1'b1;
                    t    = 0;
                end
            end else begin
                t++;
                if (t % BAUD == BAUD / 2 && t / BAUD >= 1 && t / BAUD <= 8) sh = {tx_o, sh[7:1]};
                if (t == 9 * BAUD + BAUD / 2) check("rx_stop_bit", {31'd0, tx_o}, 32'd1);
                if (t == FRAME - 1) begin
                    busy = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("rx_unexpected_frame", {24'd0, sh}, 32'hFFFF_FFFF);
                    end else begin
                        exp_byte = exp_q.pop_front();
                        check("rx_byte", {24'd0, sh}, {24'd0, exp_byte});
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{data: 8'hA5, line: 10'b1101001010, chain: 1'b0, poke: 1'b1};
        vecs[1] = '{data: 8'h00, line: 10'b1000000000, chain: 1'b1, poke: 1'b0};
        vecs[2] = '{data: 8'hFF, line: 10'b1111111110, chain: 1'b0, poke: 1'b0};
        vecs[3] = '{data: 8'h55, line: 10'b1010101010, chain: 1'b0, poke: 1'b0};
        vecs[4] = '{data: 8'hAA, line: 10'b1101010100, chain: 1'b0, poke: 1'b0};

        rst_ni  = 1'b0;
        start_i = 1'b0;
        data_i  = 8'h00;
        repeat (3) @(negedge clk_i);
        check("rst_tx", {31'd0, tx_o}, 32'd1);
        check("rst_ready", {31'd0, ready_o}, 32'd1);
        check("rst_done", {31'd0, done_o}, 32'd0);
        rst_ni = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            check("idle_tx", {31'd0, tx_o}, 32'd1);
        end

        for (int v = 0; v < 5; v++) begin
            run_vec(vecs[v], (v > 0) ? vecs[v - 1].chain : 1'b0, (v < 4) ? vecs[v + 1].data : 8'h00);
        end

        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            check("post_idle_tx", {31'd0, tx_o}, 32'd1);
            check("post_idle_done", {31'd0, done_o}, 32'd0);
        end

        // Mid-frame asynchronous reset during data bit 3 of an 8'hF0 frame
        wait_ready();
        start_i = 1'b1;
        data_i  = 8'hF0;
        exp_q.push_back(8'hF0);
        @(posedge clk_i);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk_i);
            if (i == 0) start_i = 1'b0;
            check("abort_pre_tx", {31'd0, tx_o}, 32'd0);
        end
        #2 rst_ni = 1'b0;
        #1;
        check("abort_async_tx", {31'd0, tx_o}, 32'd1);
        check("abort_ready", {31'd0, ready_o}, 32'd1);
        check("abort_done", {31'd0, done_o}, 32'd0);
        exp_q.delete();
        @(negedge clk_i);
        check("abort_hold_tx", {31'd0, tx_o}, 32'd1);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("abort_release_ready", {31'd0, ready_o}, 32'd1);

        run_vec('{data: 8'h3C, line: 10'b1001111000, chain: 1'b0, poke: 1'b0}, 1'b0, 8'h00);

        repeat (10) @(negedge clk_i);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rs232_tx.md
Name: rs232_tx

Overview:
- RS232 (UART) transmitter: serialises one parallel byte into an 8N1 frame (start bit, 8 data bits LSB first, 1 stop bit) on tx_o.
- Transmit-side counterpart of the existing rs232 receive path; sits between the system controller (byte source) and the serial pad.
- Single clock domain; bit timing comes from an internal clocks-per-bit counter.

Parameters:
- DataWidth, 8, data bits per frame.
- BaudDiv, 434, clock cycles per serial bit (for example, 50 MHz / 115200 ≈ 434). Legal range is 2..65535.
- CntWidth, 16, width of the baud counter. Must satisfy 2^CntWidth > BaudDiv.

Ports:
- clk_i  input  1  system clock. All logic is on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- start_i  input  1  request to send data_i. Sampled only while ready_o=1.
- data_i  input  DataWidth  byte to send. Captured on the accepting edge.
- ready_o  output  1  high when idle and able to accept start_i.
- done_o  output  1  one-cycle pulse when the stop bit has completed.
- tx_o  output  1  serial line. Idles high (mark).

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - state=IDLE, tx_o=1, ready_o=1, done_o=0.
  - Shift register, bit counter and baud counter all cleared.
  - Reset mid-frame aborts the frame immediately; tx_o returns to 1 without waiting for a clock.
- FSM states: IDLE, START, DATA, STOP. Outputs are registered.
  - IDLE: tx_o=1, ready_o=1. On a clk edge with start_i=1: latch data_i into the shift register, clear the baud and bit counters, go to START. tx_o=0 and ready_o=0 from the next cycle, so acceptance-to-line latency is 1 cycle.
  - START: tx_o=0 for BaudDiv cycles. When baud count reaches BaudDiv-1, go to DATA.
  - DATA: tx_o = shift_reg[0]. Each bit lasts BaudDiv cycles.
    - At the end of each bit: shift right and increment the bit counter.
    - After bit DataWidth-1: go to STOP.
  - STOP: tx_o=1 for BaudDiv cycles. At the end: done_o=1 for exactly one cycle, go to IDLE, ready_o=1 in that same cycle.
- Baud counter:
  - Counts 0..BaudDiv-1 and wraps to 0 at every bit boundary.
  - Cleared on IDLE→START.
  - Held at 0 in IDLE.
- Bit counter: width ceil(log2(DataWidth))+1; counts 0..DataWidth-1 in DATA only.
- Frame length: exactly (DataWidth+2)*BaudDiv cycles from the first tx_o=0 cycle to the done_o cycle.
- start_i / data_i changes while ready_o=0 are ignored. The frame in flight is unaffected and nothing is queued.
- Back-to-back frames: if start_i=1 in the done_o/ready_o cycle, the next frame is accepted. Its start bit follows with no idle gap beyond the stop bit.
- start_i held high continuously produces consecutive frames with the data_i value present at each acceptance edge.
- The line never glitches: tx_o is driven directly from a flop.

Decomposition:
- Package rs232_pkg holds:
  - state encoding constants (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11);
  - FRAME_BITS = DataWidth+2;
  - the shared default baud divisor, so the rx and tx ends use the same value.
- One sub-module: counter_tx, the baud/bit counter with clear/hold/increment opcode control. The FSM drives its opcode; counter_tx exposes the count and a wrap flag.
- The shift register and FSM stay in rs232_tx.

Test Plan:
- Reset: hold rst_ni=0 → tx_o=1, ready_o=1, done_o=0. Deassert, idle 50 cycles → tx_o stays 1.
- Single frame, BaudDiv=4, data_i=8'hA5, 1-cycle start_i pulse:
  - tx_o = 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles;
  - done_o pulses exactly 40 cycles after the first low cycle.
- Busy ignore: during the 8'hA5 frame, pulse start_i with data_i=8'hFF → waveform is unchanged, only one done_o.
- Back-to-back: start_i held high with data_i=8'h00, then 8'hFF → two frames with no idle cycles between the stop bit and the next start bit, and two done_o pulses 40 cycles apart.
- Mid-frame reset: assert rst_ni=0 in bit 3 of a frame → tx_o=1 asynchronously. After release, ready_o=1, and a new 8'h3C frame transmits correctly.
- Loopback: tie tx_o to the existing rs232 receiver with matching BaudDiv and send 8'h00, 8'h55, 8'hAA, 8'hFF → the received bytes match.
